// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle for one side of the SRAM-style req/addr_ok/data_ok handshake.
// The master issues requests and commands; the slave accepts them and returns read data.
interface sram_port_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one access in flight.
// Data wins ties until MAX_DATA_STREAK back-to-back data grants have starved a waiting fetch.
module sram_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input logic                 clk,
  input logic                 reset,
  sram_port_arbiter_if.slave  inst_if,
  sram_port_arbiter_if.slave  data_if,
  sram_port_arbiter_if.master mem_if
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

  logic [1:0]  state_q, state_d;
  logic        owner_data_q, owner_data_d;
  logic [3:0]  streak_q, streak_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [1:0]  cmd_size_q, cmd_size_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [3:0]  cmd_wstrb_q, cmd_wstrb_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;

  logic grant_data;
  logic grant_inst;
  logic addr_accept;
  logic resp_accept;
  logic mem_active;
  logic inst_data_ok;
  logic data_data_ok;

  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_data = data_if.req && (!inst_if.req || (streak_q < STREAK_LIMIT));
      grant_inst = inst_if.req && !grant_data;
    end
  end

  // Handshakes from memory only count in the state that is waiting for them.
  assign addr_accept = (state_q == ST_ADDR) && mem_if.addr_ok;
  assign resp_accept = (state_q == ST_RESP) && mem_if.data_ok;

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    streak_d     = streak_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_size_d   = cmd_size_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wstrb_d  = cmd_wstrb_q;
    cmd_wdata_d  = cmd_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d      = ST_ADDR;
          owner_data_d = 1'b1;
          cmd_wr_d     = data_if.wr;
          cmd_size_d   = data_if.size;
          cmd_addr_d   = data_if.addr;
          cmd_wstrb_d  = data_if.wstrb;
          cmd_wdata_d  = data_if.wdata;
          if (inst_if.req) begin
            streak_d = (streak_q >= STREAK_LIMIT) ? STREAK_LIMIT : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end else if (grant_inst) begin
          state_d      = ST_ADDR;
          owner_data_d = 1'b0;
          cmd_wr_d     = 1'b0;
          cmd_size_d   = 2'd2;
          cmd_addr_d   = inst_if.addr;
          cmd_wstrb_d  = 4'd0;
          cmd_wdata_d  = 32'd0;
          streak_d     = 4'd0;
        end
      end
      ST_ADDR: begin
        if (addr_accept) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_accept) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_data_q <= 1'b0;
      streak_q     <= 4'd0;
      cmd_wr_q     <= 1'b0;
      cmd_size_q   <= 2'd0;
      cmd_addr_q   <= 32'd0;
      cmd_wstrb_q  <= 4'd0;
      cmd_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      streak_q     <= streak_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_size_q   <= cmd_size_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wstrb_q  <= cmd_wstrb_d;
      cmd_wdata_q  <= cmd_wdata_d;
    end
  end

  // The memory command is only presented while the request is up.
  assign mem_active   = (state_q == ST_ADDR);
  assign mem_if.req   = mem_active;
  assign mem_if.wr    = mem_active & cmd_wr_q;
  assign mem_if.size  = mem_active ? cmd_size_q  : 2'd0;
  assign mem_if.addr  = mem_active ? cmd_addr_q  : 32'd0;
  assign mem_if.wstrb = mem_active ? cmd_wstrb_q : 4'd0;
  assign mem_if.wdata = mem_active ? cmd_wdata_q : 32'd0;

  assign inst_data_ok = resp_accept & ~owner_data_q;
  assign data_data_ok = resp_accept &  owner_data_q;

  assign inst_if.addr_ok = addr_accept & ~owner_data_q;
  assign inst_if.data_ok = inst_data_ok;
  assign inst_if.rdata   = inst_data_ok ? mem_if.rdata : 32'd0;

  assign data_if.addr_ok = addr_accept & owner_data_q;
  assign data_if.data_ok = data_data_ok;
  assign data_if.rdata   = data_data_ok ? mem_if.rdata : 32'd0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a transaction-level model queues expected
// memory commands and responses, and a negedge monitor pops them as the DUT handshakes.
module tb_sram_port_arbiter;

  localparam int MAX_STREAK    = 4;
  localparam int RANDOM_CYCLES = 1500;

  typedef struct packed {
    logic        isData;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        isData;
    logic [31:0] rdata;
  } resp_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  int    vectors     = 0;
  int    miscompares = 0;
  cmd_t  addrQ[$];
  resp_t respQ[$];
  string grantLog = "";

  // Reference model state: phase 0 waiting to arbitrate, 1 request out, 2 awaiting data.
  int   phase    = 0;
  int   streak   = 0;
  bit   instPend = 1'b0;
  bit   dataPend = 1'b0;
  cmd_t instCmd;
  cmd_t dataCmd;
  cmd_t cur;

  always #5 clk = ~clk;

  sram_port_arbiter_if inst_bus ();
  sram_port_arbiter_if data_bus ();
  sram_port_arbiter_if mem_bus ();

  sram_port_arbiter #(
    .MAX_DATA_STREAK(MAX_STREAK)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .inst_if(inst_bus),
    .data_if(data_bus),
    .mem_if (mem_bus)
  );

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkGrantOrder(input string want);
    vectors++;
    if (grantLog != want) begin
      miscompares++;
      $display("[TB] FAIL grant_order: got %s, want %s", grantLog, want);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_req"}, 72'(mem_bus.req), 72'd0);
    checkOutput({tag, "_mem_cmd"},
                72'({mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wstrb, mem_bus.wdata}), 72'd0);
    checkOutput({tag, "_addr_ok"}, 72'({inst_bus.addr_ok, data_bus.addr_ok}), 72'd0);
    checkOutput({tag, "_data_ok"}, 72'({inst_bus.data_ok, data_bus.data_ok}), 72'd0);
    checkOutput({tag, "_inst_rdata"}, 72'(inst_bus.rdata), 72'd0);
    checkOutput({tag, "_data_rdata"}, 72'(data_bus.rdata), 72'd0);
  endtask

  task automatic clearModel();
    phase    = 0;
    streak   = 0;
    instPend = 1'b0;
    dataPend = 1'b0;
    addrQ.delete();
    respQ.delete();
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic applyStimulus(input bit wantInst, input logic [31:0] iAddr,
                               input bit wantData, input logic dWr, input logic [1:0] dSize,
                               input logic [31:0] dAddr, input logic [3:0] dStrb,
                               input logic [31:0] dWdata, input bit mAddrOk,
                               input bit mDataOk, input logic [31:0] mRdata);
    int nextPhase;
    bit clrInst;
    bit clrData;
    clrInst = 1'b0;
    clrData = 1'b0;
    if (!instPend && wantInst) begin
      instPend = 1'b1;
      instCmd  = {1'b0, 1'b0, 2'd2, iAddr, 4'd0, 32'd0};
    end
    if (!dataPend && wantData) begin
      dataPend = 1'b1;
      dataCmd  = {1'b1, dWr, dSize, dAddr, dStrb, dWdata};
    end
    inst_bus.req   = instPend;
    inst_bus.addr  = instPend ? instCmd.addr : 32'd0;
    inst_bus.wr    = 1'b0;
    inst_bus.size  = 2'd2;
    inst_bus.wstrb = 4'd0;
    inst_bus.wdata = 32'd0;
    data_bus.req   = dataPend;
    data_bus.wr    = dataPend ? dataCmd.wr : 1'b0;
    data_bus.size  = dataPend ? dataCmd.size : 2'd0;
    data_bus.addr  = dataPend ? dataCmd.addr : 32'd0;
    data_bus.wstrb = dataPend ? dataCmd.wstrb : 4'd0;
    data_bus.wdata = dataPend ? dataCmd.wdata : 32'd0;
    mem_bus.addr_ok = mAddrOk;
    mem_bus.data_ok = mDataOk;
    mem_bus.rdata   = mRdata;

    nextPhase = phase;
    case (phase)
      0: begin
        if (dataPend && (!instPend || streak < MAX_STREAK)) begin
          cur    = dataCmd;
          streak = instPend ? ((streak < MAX_STREAK) ? streak + 1 : MAX_STREAK) : 0;
          addrQ.push_back(cur);
          nextPhase = 1;
        end else if (instPend) begin
          cur    = instCmd;
          streak = 0;
          addrQ.push_back(cur);
          nextPhase = 1;
        end
      end
      1: begin
        if (mAddrOk) begin
          if (cur.isData) clrData = 1'b1;
          else            clrInst = 1'b1;
          nextPhase = 2;
        end
      end
      default: begin
        if (mDataOk) begin
          respQ.push_back({cur.isData, mRdata});
          nextPhase = 0;
        end
      end
    endcase

    #1;
    checkOutput("mem_req_timing", 72'(mem_bus.req), 72'(phase == 1));
    @(posedge clk);
    #1;
    phase = nextPhase;
    if (clrInst) instPend = 1'b0;
    if (clrData) dataPend = 1'b0;
  endtask

  task automatic idleCycle(input bit mAddrOk, input bit mDataOk, input logic [31:0] mRdata);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 32'd0, mAddrOk, mDataOk, mRdata);
  endtask

  task automatic drainModel();
    for (int i = 0; i < 60 && (phase != 0 || instPend || dataPend); i++) begin
      idleCycle(1'b1, 1'b1, $urandom);
    end
  endtask

  // Entered at posedge+1 while the DUT shows expDataOk; reset lands mid-cycle.
  task automatic applyReset(input bit mDataOk, input logic [31:0] mRdata, input logic [1:0] expDataOk);
    inst_bus.req    = 1'b0;
    data_bus.req    = 1'b0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = mDataOk;
    mem_bus.rdata   = mRdata;
    #1;
    checkOutput("pre_reset_data_ok", 72'({inst_bus.data_ok, data_bus.data_ok}), 72'(expDataOk));
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(posedge clk);
    #1;
    mem_bus.data_ok = 1'b0;
    checkAllZero("held_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    clearModel();
  endtask

  always @(negedge clk) begin
    cmd_t        e;
    resp_t       r;
    logic [1:0]  ackBits;
    logic [1:0]  doneBits;
    logic [1:0]  ownerBits;
    logic [70:0] dutCmd;
    if (!reset) begin
      ackBits = {inst_bus.addr_ok, data_bus.addr_ok};
      dutCmd  = {mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wstrb, mem_bus.wdata};
      if (ackBits != 2'b00) begin
        if (inst_bus.addr_ok) grantLog = {grantLog, "I"};
        else                  grantLog = {grantLog, "D"};
        if (addrQ.size() == 0) begin
          checkOutput("addr_ok_unexpected", 72'(ackBits), 72'd0);
        end else begin
          e = addrQ.pop_front();
          ownerBits = e.isData ? 2'b01 : 2'b10;
          checkOutput("addr_ok_owner", 72'(ackBits), 72'(ownerBits));
          checkOutput("addr_ok_handshake", 72'({mem_bus.req, mem_bus.addr_ok}), 72'(2'b11));
          checkOutput("mem_cmd_accept", 72'(dutCmd), 72'({e.wr, e.size, e.addr, e.wstrb, e.wdata}));
        end
      end else if (mem_bus.req) begin
        if (addrQ.size() == 0) begin
          checkOutput("mem_req_unexpected", 72'(mem_bus.req), 72'd0);
        end else begin
          e = addrQ[0];
          ownerBits = e.isData ? 2'b01 : 2'b10;
          checkOutput("mem_cmd_hold", 72'(dutCmd), 72'({e.wr, e.size, e.addr, e.wstrb, e.wdata}));
          checkOutput("addr_ok_missing", 72'(ackBits), 72'(mem_bus.addr_ok ? ownerBits : 2'b00));
        end
      end

      doneBits = {inst_bus.data_ok, data_bus.data_ok};
      if (doneBits != 2'b00) begin
        if (respQ.size() == 0) begin
          checkOutput("data_ok_unexpected", 72'(doneBits), 72'd0);
        end else begin
          r = respQ.pop_front();
          ownerBits = r.isData ? 2'b01 : 2'b10;
          checkOutput("data_ok_owner", 72'(doneBits), 72'(mem_bus.data_ok ? ownerBits : 2'b00));
          checkOutput("rdata", 72'(r.isData ? data_bus.rdata : inst_bus.rdata), 72'(r.rdata));
        end
      end
      if (!inst_bus.data_ok) checkOutput("inst_rdata_zero", 72'(inst_bus.rdata), 72'd0);
      if (!data_bus.data_ok) checkOutput("data_rdata_zero", 72'(data_bus.rdata), 72'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    inst_bus.req = 1'b0;  inst_bus.wr = 1'b0;  inst_bus.size = 2'd0;
    inst_bus.addr = 32'd0; inst_bus.wstrb = 4'd0; inst_bus.wdata = 32'd0;
    data_bus.req = 1'b0;  data_bus.wr = 1'b0;  data_bus.size = 2'd0;
    data_bus.addr = 32'd0; data_bus.wstrb = 4'd0; data_bus.wdata = 32'd0;
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset_state");
    reset = 1'b0;
    clearModel();

    $display("[TB] single instruction read");
    applyStimulus(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    idleCycle(1'b1, 1'b0, 32'd0);
    idleCycle(1'b0, 1'b1, 32'h0280_0413);

    $display("[TB] byte data write");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 2'd0, 32'h1C01_0003, 4'b1000, 32'hAB00_0000,
                  1'b0, 1'b0, 32'd0);
    idleCycle(1'b1, 1'b0, 32'd0);
    idleCycle(1'b0, 1'b1, 32'h5555_AAAA);

    $display("[TB] memory stall");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'd2, 32'h1C02_0000, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) idleCycle(1'b0, k[0], $urandom);
    idleCycle(1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) idleCycle(1'b1, 1'b0, $urandom);
    idleCycle(1'b0, 1'b1, 32'h1234_5678);

    $display("[TB] starvation guard");
    grantLog = "";
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b1, $urandom, 1'b1, 1'($urandom), 2'($urandom_range(0, 2)), $urandom,
                    4'($urandom), $urandom, 1'b1, 1'b1, $urandom);
    end
    checkGrantOrder("DDDDIDDDDI");
    drainModel();

    $display("[TB] reset while awaiting read data");
    applyStimulus(1'b1, 32'h1C00_0040, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    idleCycle(1'b1, 1'b0, 32'd0);
    applyReset(1'b1, 32'hDEAD_BEEF, 2'b10);
    idleCycle(1'b0, 1'b1, 32'hCAFE_F00D);
    idleCycle(1'b1, 1'b0, 32'd0);

    $display("[TB] spurious memory handshakes while idle");
    for (int k = 0; k < 4; k++) idleCycle(1'b1, 1'b1, $urandom);
    applyStimulus(1'b1, 32'h1C00_0080, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    idleCycle(1'b1, 1'b0, 32'd0);
    idleCycle(1'b0, 1'b1, 32'h0000_BEEF);

    $display("[TB] randomized traffic");
    for (int k = 0; k < RANDOM_CYCLES; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom_range(0, 2)),
                    $urandom, 4'($urandom), $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
    end
    drainModel();
    idleCycle(1'b0, 1'b0, 32'd0);
    checkOutput("addr_queue_drained", 72'(addrQ.size()), 72'd0);
    checkOutput("resp_queue_drained", 72'(respQ.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one memory port between the CPU instruction-fetch requester and the data-access requester.
- Uses a req/addr_ok/data_ok handshake on all three sides.
- Sits between the pipeline's IF/EX-stage memory interfaces and the single memory port.
- Data requests take priority; a streak counter keeps instruction fetch from starving.
- One transaction is outstanding at a time.

Parameters:
- MAX_DATA_STREAK, 4, number of consecutive data grants allowed while inst_req is pending before inst is granted once (range 1..15).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- inst_req  input  1  instruction read request; held stable until inst_addr_ok
- inst_addr  input  32  instruction byte address
- inst_addr_ok  output  1  one-cycle pulse: inst request accepted by memory
- inst_data_ok  output  1  one-cycle pulse: inst read data valid
- inst_rdata  output  32  read data; 0 when inst_data_ok=0
- data_req  input  1  data request; held stable until data_addr_ok
- data_wr  input  1  1=write, 0=read
- data_size  input  2  0=byte, 1=half, 2=word
- data_addr  input  32  data byte address
- data_wstrb  input  4  byte write strobes
- data_wdata  input  32  write data
- data_addr_ok  output  1  one-cycle pulse: data request accepted
- data_data_ok  output  1  one-cycle pulse: read data valid / write done
- data_rdata  output  32  read data; 0 when data_data_ok=0
- mem_req  output  1  request to memory
- mem_wr  output  1  write flag
- mem_size  output  2  access size
- mem_addr  output  32  address
- mem_wstrb  output  4  strobes
- mem_wdata  output  32  write data
- mem_addr_ok  input  1  memory accepted request
- mem_data_ok  input  1  memory response valid
- mem_rdata  input  32  memory read data

Behaviour:
- Reset state: FSM in IDLE, owner=inst, streak_cnt=0, command register cleared. All outputs are 0.
- Reset mid-transaction drops the outstanding access; any mem_data_ok that arrives after reset deasserts is ignored.
- FSM states: IDLE, ADDR, RESP.
- IDLE, arbitration:
  - No request: stay in IDLE.
  - Only one of inst_req/data_req high: grant that requester.
  - Both high: grant data if streak_cnt<MAX_DATA_STREAK, otherwise grant inst.
  - On grant, latch the winner's command into the command register and set owner. Inst is always latched as a read with size=2, wstrb=0, wdata=0.
  - Go to ADDR.
- ADDR:
  - mem_req=1; mem_wr/size/addr/wstrb/wdata are driven from the command register.
  - On mem_addr_ok, the owner's addr_ok pulses in the same cycle and the FSM goes to RESP.
  - Otherwise the request is held unchanged.
- RESP:
  - mem_req=0.
  - On mem_data_ok, the owner's data_ok pulses in the same cycle and the owner's rdata = mem_rdata (combinational pass-through). The FSM returns to IDLE.
  - Writes also complete on mem_data_ok; data_rdata is don't-care (driven to mem_rdata).
  - The non-owner's addr_ok and data_ok are always 0.
- Streak counter (updated only on grant):
  - Data granted while inst_req=1: streak_cnt+1, saturating at MAX_DATA_STREAK.
  - Inst granted, or data granted while inst_req=0: streak_cnt=0.
- Minimum latency, with memory answering at the earliest opportunity:
  - req sampled in cycle 0 (IDLE).
  - mem_req and addr_ok in cycle 1.
  - data_ok in cycle 2.
  - Next arbitration in cycle 3. Throughput is therefore at most 1 access per 3 cycles.
- Requesters drop or change req only after their addr_ok. A req that appears during ADDR/RESP waits for IDLE.
- mem_addr_ok or mem_data_ok arriving in IDLE, or in the wrong state, is ignored.
- Address and size alignment are not checked; they pass through unchanged.

Test Plan:
- Single inst read: inst_req=1, inst_addr=0x1C000000; mem_addr_ok in cycle 1, mem_data_ok with mem_rdata=0x02800413 in cycle 2 -> inst_addr_ok in cycle 1, inst_data_ok with inst_rdata=0x02800413 in cycle 2, mem_wr=0, mem_size=2.
- Data write: data_wr=1, data_size=0, data_addr=0x1C010003, data_wstrb=4'b1000, data_wdata=0xAB000000 -> mem_* carries exactly these values; data_data_ok pulses on mem_data_ok; inst_* outputs stay 0.
- Simultaneous requests with MAX_DATA_STREAK=4: data_req and inst_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I; streak_cnt reads 0 after each I grant.
- Memory stall: mem_addr_ok held low for 5 cycles -> mem_req and all mem_* fields stay constant and no addr_ok pulses; then a single addr_ok pulse; a 3-cycle mem_data_ok delay produces a single data_ok pulse.
- Reset in RESP: assert reset while waiting for mem_data_ok -> all outputs 0 immediately (asynchronous); after release, a spurious mem_data_ok produces no data_ok and the FSM stays in IDLE.
- Spurious mem_addr_ok or mem_data_ok in IDLE -> no addr_ok/data_ok pulses and no state change.
